// File: rtl/systolic_result_writer_pkg.sv
// Shared types and widths for the systolic-array memory write-back path.
package systolic_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int BANDWIDTH  = 4;
    localparam int DIM_WIDTH  = 8;
    localparam int MAT_DIM    = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FINISH = 2'd2} wr_state_t;

    typedef logic [ADDR_WIDTH-1:0]                  addr_t;
    typedef logic [BANDWIDTH-1:0][DATA_WIDTH-1:0]   beat_t;
    typedef logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] mat_t;
endpackage

// File: rtl/systolic_result_writer_if.sv
// Memory write bus: one BANDWIDTH-word beat per accepted cycle.
interface systolic_result_writer_if;
    import systolic_pkg::*;

    logic  write;
    logic  write_ready;
    addr_t write_addr;
    beat_t writedata;

    modport master (output write, write_addr, writedata, input write_ready);
    modport slave  (input write, write_addr, writedata, output write_ready);
endinterface

// File: rtl/systolic_result_writer_addr_gen.sv
// Row/chunk walker for the write-back; the row base is accumulated so the
// beat address never needs a multiplier.
module writer_addr_gen import systolic_pkg::*; #(
    parameter  int MAT_DIM   = 8,
    localparam int BEATS_ROW = MAT_DIM / BANDWIDTH,
    localparam int RW        = $clog2(MAT_DIM),
    localparam int CW        = (BEATS_ROW > 1) ? $clog2(BEATS_ROW) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic                 i_adv,
    input  addr_t                i_base,
    input  logic [DIM_WIDTH-1:0] i_dim,
    output logic [RW-1:0]        o_row,
    output logic [CW-1:0]        o_chunk,
    output addr_t                o_addr,
    output logic                 o_last
);
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_chunk;
    addr_t         r_row_base;
    addr_t         r_dim;
    logic          w_row_end;

    assign w_row_end = (r_chunk == CW'(BEATS_ROW - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row      <= '0;
            r_chunk    <= '0;
            r_row_base <= '0;
            r_dim      <= '0;
        end else if (i_load) begin
            r_row      <= '0;
            r_chunk    <= '0;
            r_row_base <= i_base;
            r_dim      <= addr_t'(i_dim);
        end else if (i_adv) begin
            if (w_row_end) begin
                r_chunk    <= '0;
                r_row      <= r_row + RW'(1);
                r_row_base <= r_row_base + r_dim;
            end else begin
                r_chunk    <= r_chunk + CW'(1);
            end
        end
    end

    // Chunk offset is a constant scale, wraps naturally in ADDR_WIDTH bits
    assign o_addr  = r_row_base + addr_t'(r_chunk) * addr_t'(BANDWIDTH);
    assign o_row   = r_row;
    assign o_chunk = r_chunk;
    assign o_last  = (r_row == RW'(MAT_DIM - 1)) && w_row_end;
endmodule

// File: rtl/systolic_result_writer.sv
// Snapshots the result matrix on start and streams it to memory row-major,
// BANDWIDTH words per beat, under write/write_ready flow control.
module systolic_result_writer import systolic_pkg::*; #(
    parameter int MAT_DIM = systolic_pkg::MAT_DIM
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  addr_t                base_C,
    input  logic [DIM_WIDTH-1:0] dim_col_C,
    input  logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] Out,
    systolic_result_writer_if.master wr,
    output logic                 busy,
    output logic                 done
);
    localparam int BEATS_ROW = MAT_DIM / BANDWIDTH;
    localparam int RW  = $clog2(MAT_DIM);
    localparam int CW  = (BEATS_ROW > 1) ? $clog2(BEATS_ROW) : 1;
    localparam int CLW = $clog2(MAT_DIM);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WRITE  = WRITE;
    localparam logic [1:0] S_FINISH = FINISH;

    if ((MAT_DIM % BANDWIDTH) != 0) begin : g_bad_dim
        $error("MAT_DIM must be a multiple of BANDWIDTH");
    end

    logic [1:0]    r_state;
    logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] r_snap;
    logic          w_load, w_accept, w_last, w_write;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_chunk;
    addr_t         w_addr;
    beat_t         w_beat;
    logic [MAT_DIM-1:0][DATA_WIDTH-1:0] w_row_words;

    // start is only honoured in IDLE, so a pulse during WRITE/FINISH is dropped
    assign w_load   = (r_state == S_IDLE) && start;
    assign w_write  = (r_state == S_WRITE);
    assign w_accept = w_write && wr.write_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) r_state <= S_WRITE;
                S_WRITE:  if (w_accept && w_last) r_state <= S_FINISH;
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_load) r_snap <= Out;
    end

    writer_addr_gen #(.MAT_DIM(MAT_DIM)) u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_adv   (w_accept),
        .i_base  (base_C),
        .i_dim   (dim_col_C),
        .o_row   (w_row),
        .o_chunk (w_chunk),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    assign w_row_words = r_snap[w_row];

    for (genvar gi = 0; gi < BANDWIDTH; gi++) begin : g_lane
        logic [CLW-1:0] w_col;
        assign w_col      = CLW'(int'(w_chunk) * BANDWIDTH + gi);
        assign w_beat[gi] = w_row_words[w_col];
    end

    assign wr.write      = w_write;
    assign wr.write_addr = w_write ? w_addr : '0;
    assign wr.writedata  = w_write ? w_beat : '0;
    assign busy          = w_write;
    assign done          = (r_state == S_FINISH);
endmodule

// File: tb/tb_systolic_result_writer.sv
// Scoreboard bench: expected beats queued at start, monitor pops on each accepted beat.
module tb_systolic_result_writer;
    import systolic_pkg::*;

    localparam int MEMSZ = 1 << ADDR_WIDTH;
    localparam int BW    = BANDWIDTH;
    localparam int MD    = MAT_DIM;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    addr_t                base_C = '0;
    logic [DIM_WIDTH-1:0] dim_col_C = '0;
    mat_t                 Out = '0;
    logic                 busy, done;

    systolic_result_writer_if wr();

    systolic_result_writer #(.MAT_DIM(MD)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_C    (base_C),
        .dim_col_C (dim_col_C),
        .Out       (Out),
        .wr        (wr),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {addr_t addr; beat_t data;} exp_t;

    logic [31:0] mem [MEMSZ];
    logic [31:0] exp_mem [MEMSZ];
    exp_t        q[$];
    int checks = 0, errors = 0;
    int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
    int start_cyc = 0, stall_cnt = 0;
    bit rdy_rand = 1'b0, stalled = 1'b0;
    addr_t held_addr;
    beat_t held_data;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic logic [31:0] fbits(int n);
        int e = 0;
        if (n == 0) return 32'h0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic mat_t fmat();
        mat_t m;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) m[r][c] = fbits(r * MD + c);
        return m;
    endfunction

    function automatic mat_t rmat();
        mat_t m;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) m[r][c] = $urandom;
        return m;
    endfunction

    function automatic int wa(int a);
        return int'(addr_t'(a));
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        wr.write_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            wr.write_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare each accepted beat, check stall stability, capture into memory
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (wr.write === 1'b1) begin
            chk("addr_known", 128'($isunknown(wr.write_addr)), 128'(0));
            if (stalled) begin
                chk("stall_addr", 128'(wr.write_addr), 128'(held_addr));
                chk("stall_data", wr.writedata, held_data);
            end
            if (wr.write_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
                else begin
                    e = q.pop_front();
                    chk("beat_addr", 128'(wr.write_addr), 128'(e.addr));
                    chk("beat_data", wr.writedata, e.data);
                end
                for (int i = 0; i < BW; i++)
                    mem[wa(int'(wr.write_addr) + i)] = wr.writedata[i];
                beats++;
                if (beats == 1) first_cyc = cyc;
                last_cyc = cyc;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                stall_cnt++;
                held_addr = wr.write_addr;
                held_data = wr.writedata;
            end
        end else begin
            stalled = 1'b0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic prefill();
        for (int a = 0; a < MEMSZ; a++) mem[a] = 32'hDEADBEEF;
    endtask

    // Reference: word-level image of the matrix, rows applied in order so later rows win
    task automatic launch(addr_t b, logic [DIM_WIDTH-1:0] d, mat_t m);
        exp_t e;
        for (int a = 0; a < MEMSZ; a++) exp_mem[a] = mem[a];
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++)
                exp_mem[wa(int'(b) + r * int'(d) + c)] = m[r][c];
            for (int k = 0; k < MD / BW; k++) begin
                e.addr = addr_t'(int'(b) + r * int'(d) + k * BW);
                for (int i = 0; i < BW; i++) e.data[i] = m[r][k * BW + i];
                q.push_back(e);
            end
        end
        Out = m; base_C = b; dim_col_C = d;
        beats = 0;
        start = 1'b1;
        start_cyc = cyc;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 400) begin
            cycle();
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 128'(0), 128'(1));
        cycle();
        cycle();
        chk("queue_drained", 128'(q.size()), 128'(0));
    endtask

    task automatic check_mem(string nm);
        int mism = 0;
        for (int a = 0; a < MEMSZ; a++) if (mem[a] !== exp_mem[a]) mism++;
        chk(nm, 128'(mism), 128'(0));
    endtask

    initial begin
        mat_t fm, m1, m2;
        int mism, d0;
        fm = fmat();

        repeat (3) cycle();
        chk("rst_write", 128'(wr.write), 128'(0));
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_done",  128'(done), 128'(0));
        chk("rst_addr",  128'(wr.write_addr), 128'(0));
        chk("rst_data",  wr.writedata, 128'(0));
        reset_n = 1'b1;
        cycle();

        // 1: contiguous rows, ready tied high, latency
        prefill();
        launch(addr_t'(200), 8'd8, fm);
        chk("s1_busy", 128'(busy), 128'(1));
        wait_done();
        chk("s1_first_beat", 128'(first_cyc - start_cyc), 128'(1));
        chk("s1_last_beat",  128'(last_cyc - start_cyc), 128'(16));
        chk("s1_done_cyc",   128'(done_cyc - start_cyc), 128'(17));
        chk("s1_beats",      128'(beats), 128'(16));
        mism = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                if (mem[200 + r * 8 + c] !== fbits(r * 8 + c)) mism++;
        chk("s1_image", 128'(mism), 128'(0));
        check_mem("s1_mem");

        // 2: stride 12 leaves gaps untouched
        prefill();
        launch(addr_t'(0), 8'd12, fm);
        wait_done();
        mism = 0;
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) if (mem[12 * r + c] !== fbits(r * 8 + c)) mism++;
            for (int c = 8; c < 12; c++) if (mem[12 * r + c] !== 32'hDEADBEEF) mism++;
        end
        chk("s2_image", 128'(mism), 128'(0));
        check_mem("s2_mem");

        // 3: random backpressure
        prefill();
        stall_cnt = 0;
        rdy_rand = 1'b1;
        launch(addr_t'(200), 8'd8, fm);
        wait_done();
        rdy_rand = 1'b0;
        chk("s3_beats", 128'(beats), 128'(16));
        chk("s3_stalls_seen", 128'(stall_cnt > 0), 128'(1));
        check_mem("s3_mem");

        // 4: restart attempt while busy is ignored
        prefill();
        d0 = done_cnt;
        launch(addr_t'(200), 8'd8, fm);
        repeat (4) cycle();
        Out = rmat(); base_C = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done();
        repeat (20) cycle();
        chk("s4_one_done", 128'(done_cnt - d0), 128'(1));
        chk("s4_done_cyc", 128'(done_cyc - start_cyc), 128'(17));
        check_mem("s4_mem");

        // 5: reset mid-transfer, then a clean transfer
        prefill();
        m1 = rmat();
        launch(addr_t'(200), 8'd8, m1);
        repeat (5) cycle();
        reset_n = 1'b0;
        #1;
        chk("s5_write_drop", 128'(wr.write), 128'(0));
        chk("s5_busy_drop",  128'(busy), 128'(0));
        q.delete();
        d0 = done_cnt;
        repeat (4) cycle();
        chk("s5_no_done", 128'(done_cnt), 128'(d0));
        reset_n = 1'b1;
        cycle();
        m2 = rmat();
        launch(addr_t'(200), 8'd8, m2);
        wait_done();
        check_mem("s5_mem");

        // 6: address wrap at top of memory
        prefill();
        m1 = rmat();
        launch(addr_t'(MEMSZ - 4), 8'd8, m1);
        wait_done();
        mism = 0;
        for (int c = 0; c < 4; c++) if (mem[c] !== m1[0][4 + c]) mism++;
        chk("s6_wrap", 128'(mism), 128'(0));
        check_mem("s6_mem");

        // Random mix: overlapping strides, zero stride, backpressure
        for (int t = 0; t < 6; t++) begin
            logic [DIM_WIDTH-1:0] d;
            case (t % 3)
                0: d = 8'd0;
                1: d = 8'($urandom_range(1, 7));
                default: d = 8'($urandom_range(8, 255));
            endcase
            rdy_rand = 1'($urandom_range(0, 1));
            m1 = rmat();
            base_C = addr_t'($urandom);
            launch(base_C, d, m1);
            wait_done();
            rdy_rand = 1'b0;
            if (d == 8'd0) begin
                mism = 0;
                for (int c = 0; c < MD; c++)
                    if (mem[wa(int'(base_C) + c)] !== m1[MD - 1][c]) mism++;
                chk("rnd_dim0_last_row", 128'(mism), 128'(0));
            end
            check_mem("rnd_mem");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
